// File: rtl/rob_commit_unit.sv
// In-order reorder buffer: allocates on issue, captures CDB results, retires the head
// through the RegFile write port and flushes on a branch mispredict at commit.
// Optional macro ROB_FWD_EN adds two combinational operand lookup/forwarding ports.
module rob_commit_unit #(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy_i,
  input  logic             issue_valid_i,
  input  logic [4:0]       issue_rd_i,
  input  logic             issue_is_br_i,
  input  logic [XLEN-1:0]  issue_pred_pc_i,
  output logic             full_o,
  output logic             upd_o,
  output logic [IDX_W-1:0] upd_idx_o,
  output logic [4:0]       upd_rd_o,
  input  logic             cdb_valid_i,
  input  logic [IDX_W-1:0] cdb_idx_i,
  input  logic [XLEN-1:0]  cdb_val_i,
  input  logic [XLEN-1:0]  cdb_npc_i,
  output logic             write_o,
  output logic [IDX_W-1:0] write_idx_o,
  output logic [4:0]       write_rd_o,
  output logic [XLEN-1:0]  new_val_o,
`ifdef ROB_FWD_EN
  input  logic [IDX_W-1:0] q1_idx_i,
  input  logic [IDX_W-1:0] q2_idx_i,
  output logic             q1_rdy_o,
  output logic             q2_rdy_o,
  output logic [XLEN-1:0]  q1_val_o,
  output logic [XLEN-1:0]  q2_val_o,
`endif
  output logic             jp_wrong_o,
  output logic [XLEN-1:0]  jp_pc_o
);

  localparam int unsigned Depth = 2 ** IDX_W;

  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;
  logic [Depth-1:0] busy_q, busy_d, ready_q, ready_d;
  logic             jp_wrong_q, jp_wrong_d;
  logic [XLEN-1:0]  jp_pc_q, jp_pc_d;

  logic [4:0]       rd_q      [Depth];
  logic             is_br_q   [Depth];
  logic [XLEN-1:0]  pred_pc_q [Depth];
  logic [XLEN-1:0]  val_q     [Depth];
  logic [XLEN-1:0]  npc_q     [Depth];

  logic cdb_hit, mispredict;

  // Handshake outputs and commit/mispredict decode from the current head.
  always_comb begin
    full_o      = (count_q == (IDX_W+1)'(Depth)) | jp_wrong_q;
    upd_o       = rdy_i & issue_valid_i & ~full_o;
    upd_idx_o   = tail_q;
    upd_rd_o    = issue_rd_i;
    write_o     = rdy_i & ~jp_wrong_q & busy_q[head_q] & ready_q[head_q];
    write_idx_o = head_q;
    write_rd_o  = rd_q[head_q];
    new_val_o   = val_q[head_q];
    jp_wrong_o  = jp_wrong_q;
    jp_pc_o     = jp_pc_q;
    cdb_hit     = cdb_valid_i & ~jp_wrong_q & busy_q[cdb_idx_i];
    mispredict  = write_o & is_br_q[head_q] & (npc_q[head_q] != pred_pc_q[head_q]);
  end

  // Next-state for pointers, occupancy flags and the flush pulse.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    busy_d     = busy_q;
    ready_d    = ready_q;
    jp_wrong_d = 1'b0;
    jp_pc_d    = jp_pc_q;
    count_d    = count_q + (IDX_W+1)'(upd_o) - (IDX_W+1)'(write_o);
    if (cdb_hit) ready_d[cdb_idx_i] = 1'b1;
    if (upd_o) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = 1'b0;
      tail_d          = tail_q + 1'b1;
    end
    if (write_o) begin
      busy_d[head_q]  = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    // Flush wins over any same-cycle allocation.
    if (mispredict) begin
      busy_d     = '0;
      ready_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      jp_wrong_d = 1'b1;
      jp_pc_d    = npc_q[head_q];
    end
  end

  // Control state register; rdy_i low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      busy_q     <= '0;
      ready_q    <= '0;
      jp_wrong_q <= 1'b0;
      jp_pc_q    <= '0;
    end else if (rdy_i) begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      jp_wrong_q <= jp_wrong_d;
      jp_pc_q    <= jp_pc_d;
    end
  end

  // Entry payload; qualified by busy/ready so it needs no reset.
  always_ff @(posedge clk) begin
    if (rdy_i) begin
      if (upd_o) begin
        rd_q[tail_q]      <= issue_rd_i;
        is_br_q[tail_q]   <= issue_is_br_i;
        pred_pc_q[tail_q] <= issue_pred_pc_i;
      end
      if (cdb_hit) begin
        val_q[cdb_idx_i] <= cdb_val_i;
        npc_q[cdb_idx_i] <= cdb_npc_i;
      end
    end
  end

`ifdef ROB_FWD_EN
  // Operand lookup with bypass of a same-cycle CDB broadcast.
  always_comb begin
    q1_rdy_o = busy_q[q1_idx_i] & ready_q[q1_idx_i];
    q1_val_o = val_q[q1_idx_i];
    q2_rdy_o = busy_q[q2_idx_i] & ready_q[q2_idx_i];
    q2_val_o = val_q[q2_idx_i];
    if (cdb_valid_i && cdb_idx_i == q1_idx_i) begin
      q1_rdy_o = 1'b1;
      q1_val_o = cdb_val_i;
    end
    if (cdb_valid_i && cdb_idx_i == q2_idx_i) begin
      q2_rdy_o = 1'b1;
      q2_val_o = cdb_val_i;
    end
  end
`endif

endmodule

// File: tb/tb_rob_commit_unit.sv
// Self-checking bench for rob_commit_unit: vector table for wrap-around, hand sequences
// for full/mispredict/stall, and a commit scoreboard fed at issue time.
module tb_rob_commit_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy_i = 1'b1;
  logic        issue_valid_i = 1'b0;
  logic [4:0]  issue_rd_i = '0;
  logic        issue_is_br_i = 1'b0;
  logic [31:0] issue_pred_pc_i = '0;
  logic        full_o, upd_o;
  logic [3:0]  upd_idx_o;
  logic [4:0]  upd_rd_o;
  logic        cdb_valid_i = 1'b0;
  logic [3:0]  cdb_idx_i = '0;
  logic [31:0] cdb_val_i = '0;
  logic [31:0] cdb_npc_i = '0;
  logic        write_o;
  logic [3:0]  write_idx_o;
  logic [4:0]  write_rd_o;
  logic [31:0] new_val_o;
  logic        jp_wrong_o;
  logic [31:0] jp_pc_o;
`ifdef ROB_FWD_EN
  logic [3:0]  q1_idx_i = '0, q2_idx_i = '0;
  logic        q1_rdy_o, q2_rdy_o;
  logic [31:0] q1_val_o, q2_val_o;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  idx;
    logic [4:0]  rd;
    logic [31:0] val;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
    logic [3:0]  exp_idx;
  } vec_t;
  vec_t vecs[20];

  rob_commit_unit dut (
    .clk(clk), .rst(rst), .rdy_i(rdy_i),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i), .issue_is_br_i(issue_is_br_i),
    .issue_pred_pc_i(issue_pred_pc_i),
    .full_o(full_o), .upd_o(upd_o), .upd_idx_o(upd_idx_o), .upd_rd_o(upd_rd_o),
    .cdb_valid_i(cdb_valid_i), .cdb_idx_i(cdb_idx_i), .cdb_val_i(cdb_val_i),
    .cdb_npc_i(cdb_npc_i),
    .write_o(write_o), .write_idx_o(write_idx_o), .write_rd_o(write_rd_o),
    .new_val_o(new_val_o),
`ifdef ROB_FWD_EN
    .q1_idx_i(q1_idx_i), .q2_idx_i(q2_idx_i), .q1_rdy_o(q1_rdy_o), .q2_rdy_o(q2_rdy_o),
    .q1_val_o(q1_val_o), .q2_val_o(q2_val_o),
`endif
    .jp_wrong_o(jp_wrong_o), .jp_pc_o(jp_pc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every commit must match the oldest outstanding issue.
  always @(negedge clk) begin
    if (!rst && write_o) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_commit", {28'd0, write_idx_o}, 32'hFFFF_FFFF);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("commit_idx", {28'd0, write_idx_o}, {28'd0, e.idx});
        chk("commit_rd", {27'd0, write_rd_o}, {27'd0, e.rd});
        chk("commit_val", new_val_o, e.val);
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rdy_i = 1'b1;
    issue_valid_i = 1'b0;
    issue_is_br_i = 1'b0;
    cdb_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    next();
    next();
    rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic issue(input logic [4:0] rd, input logic br, input logic [31:0] pred);
    issue_valid_i = 1'b1;
    issue_rd_i = rd;
    issue_is_br_i = br;
    issue_pred_pc_i = pred;
  endtask

  task automatic cdb(input logic [3:0] idx, input logic [31:0] val, input logic [31:0] npc);
    cdb_valid_i = 1'b1;
    cdb_idx_i = idx;
    cdb_val_i = val;
    cdb_npc_i = npc;
  endtask

  initial begin
    for (int i = 0; i < 20; i++) begin
      vecs[i].rd = 5'((i % 31) + 1);
      vecs[i].val = 32'hA000_0000 + 32'(i * 3);
      vecs[i].exp_idx = 4'(i % 16);
    end

    // 1: reset state and basic issue -> CDB -> commit
    do_reset();
    @(negedge clk);
    chk("rst_full", {31'd0, full_o}, 32'd0);
    chk("rst_upd", {31'd0, upd_o}, 32'd0);
    chk("rst_write", {31'd0, write_o}, 32'd0);
    chk("rst_jp_wrong", {31'd0, jp_wrong_o}, 32'd0);
    chk("rst_jp_pc", jp_pc_o, 32'd0);
    next();
    issue(5'd5, 1'b0, 32'd0);
    sb_q.push_back('{idx: 4'd0, rd: 5'd5, val: 32'h1234});
    @(negedge clk);
    chk("t1_upd", {31'd0, upd_o}, 32'd1);
    chk("t1_upd_idx", {28'd0, upd_idx_o}, 32'd0);
    chk("t1_upd_rd", {27'd0, upd_rd_o}, 32'd5);
    next();
    idle();
    cdb(4'd0, 32'h1234, 32'd0);
    @(negedge clk);
    chk("t1_no_same_cycle_write", {31'd0, write_o}, 32'd0);
    next();
    idle();
    @(negedge clk);
    chk("t1_write", {31'd0, write_o}, 32'd1);
    next();
    @(negedge clk);
    chk("t1_write_done", {31'd0, write_o}, 32'd0);

    // 2: fill to 16, 17th rejected, one commit frees a slot
    do_reset();
    for (int i = 0; i < 16; i++) begin
      issue(5'(i + 1), 1'b0, 32'd0);
      sb_q.push_back('{idx: 4'(i), rd: 5'(i + 1), val: 32'hB000 + 32'(i)});
      @(negedge clk);
      chk("t2_not_full", {31'd0, full_o}, 32'd0);
      chk("t2_upd_idx", {28'd0, upd_idx_o}, 32'(i));
      next();
    end
    @(negedge clk);
    chk("t2_full", {31'd0, full_o}, 32'd1);
    chk("t2_17th_upd", {31'd0, upd_o}, 32'd0);
    next();
    idle();
    cdb(4'd0, 32'hB000, 32'd0);
    next();
    idle();
    @(negedge clk);
    chk("t2_commit", {31'd0, write_o}, 32'd1);
    chk("t2_full_during_commit", {31'd0, full_o}, 32'd1);
    next();
    @(negedge clk);
    chk("t2_full_cleared", {31'd0, full_o}, 32'd0);

    // 3: wrap-around via vector table
    do_reset();
    for (int i = 0; i < 20; i++) begin
      issue(vecs[i].rd, 1'b0, 32'd0);
      sb_q.push_back('{idx: vecs[i].exp_idx, rd: vecs[i].rd, val: vecs[i].val});
      @(negedge clk);
      chk("t3_upd", {31'd0, upd_o}, 32'd1);
      chk("t3_upd_idx", {28'd0, upd_idx_o}, {28'd0, vecs[i].exp_idx});
      next();
      idle();
      cdb(vecs[i].exp_idx, vecs[i].val, 32'd0);
      next();
      idle();
      @(negedge clk);
      chk("t3_write", {31'd0, write_o}, 32'd1);
      next();
    end

    // 4: mispredict flush
    do_reset();
    issue(5'd1, 1'b1, 32'h100);
    sb_q.push_back('{idx: 4'd0, rd: 5'd1, val: 32'h55});
    next();
    for (int i = 0; i < 3; i++) begin
      issue(5'(i + 2), 1'b0, 32'd0);
      next();
    end
    idle();
    cdb(4'd0, 32'h55, 32'h200);
    cdb_valid_i = 1'b1;
    next();
    cdb(4'd1, 32'h66, 32'd0);  // younger entry completes alongside the branch commit
    issue(5'd6, 1'b0, 32'd0);  // discarded by the flush
    @(negedge clk);
    chk("t4_br_commit", {31'd0, write_o}, 32'd1);
    chk("t4_no_jp_yet", {31'd0, jp_wrong_o}, 32'd0);
    next();
    cdb(4'd2, 32'h77, 32'd0);
    @(negedge clk);
    chk("t4_jp_wrong", {31'd0, jp_wrong_o}, 32'd1);
    chk("t4_jp_pc", jp_pc_o, 32'h200);
    chk("t4_full_in_flush", {31'd0, full_o}, 32'd1);
    chk("t4_no_upd_in_flush", {31'd0, upd_o}, 32'd0);
    chk("t4_no_write_in_flush", {31'd0, write_o}, 32'd0);
    next();
    sb_q.delete();
    idle();
    issue(5'd9, 1'b0, 32'd0);
    sb_q.push_back('{idx: 4'd0, rd: 5'd9, val: 32'h88});
    @(negedge clk);
    chk("t4_jp_cleared", {31'd0, jp_wrong_o}, 32'd0);
    chk("t4_upd_after", {31'd0, upd_o}, 32'd1);
    chk("t4_upd_idx_after", {28'd0, upd_idx_o}, 32'd0);
    next();
    idle();
    cdb(4'd1, 32'h99, 32'd0);  // stale index, not allocated since flush
    next();
    idle();
    @(negedge clk);
    chk("t4_no_stale_write", {31'd0, write_o}, 32'd0);
    next();
    cdb(4'd0, 32'h88, 32'd0);
    next();
    idle();
    @(negedge clk);
    chk("t4_write_after", {31'd0, write_o}, 32'd1);
    next();

    // 5: rdy=0 freezes state
    do_reset();
    issue(5'd7, 1'b0, 32'd0);
    sb_q.push_back('{idx: 4'd0, rd: 5'd7, val: 32'h99});
    next();
    idle();
    rdy_i = 1'b0;
    issue(5'd3, 1'b0, 32'd0);
    cdb(4'd0, 32'h99, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t5_stall_upd", {31'd0, upd_o}, 32'd0);
      chk("t5_stall_write", {31'd0, write_o}, 32'd0);
      next();
    end
    idle();
    @(negedge clk);
    chk("t5_cdb_frozen", {31'd0, write_o}, 32'd0);
    next();
    issue(5'd8, 1'b0, 32'd0);
    sb_q.push_back('{idx: 4'd1, rd: 5'd8, val: 32'hAB});
    @(negedge clk);
    chk("t5_issue_frozen", {28'd0, upd_idx_o}, 32'd1);
    next();
    idle();
    cdb(4'd0, 32'h99, 32'd0);
    next();
    idle();
    cdb(4'd1, 32'hAB, 32'd0);
    @(negedge clk);
    chk("t5_write0", {31'd0, write_o}, 32'd1);
    next();
    idle();
    rdy_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t5_hold_write", {31'd0, write_o}, 32'd0);
      next();
    end
    rdy_i = 1'b1;
    @(negedge clk);
    chk("t5_resume_write", {31'd0, write_o}, 32'd1);
    chk("t5_resume_head", {28'd0, write_idx_o}, 32'd1);
    next();

`ifdef ROB_FWD_EN
    // 6: operand lookup with same-cycle CDB forwarding
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue(5'(i + 1), 1'b0, 32'd0);
      next();
    end
    idle();
    q1_idx_i = 4'd2;
    @(negedge clk);
    chk("t6_q1_not_rdy", {31'd0, q1_rdy_o}, 32'd0);
    next();
    cdb(4'd2, 32'hAA, 32'd0);
    @(negedge clk);
    chk("t6_q1_fwd_rdy", {31'd0, q1_rdy_o}, 32'd1);
    chk("t6_q1_fwd_val", q1_val_o, 32'hAA);
    next();
    idle();
    @(negedge clk);
    chk("t6_q1_stored_rdy", {31'd0, q1_rdy_o}, 32'd1);
    chk("t6_q1_stored_val", q1_val_o, 32'hAA);
    do_reset();
`endif

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
